// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: sequencer state encoding, control-field widths
// and the per-cycle action chosen by the hazard controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_MUL = 2'd1,
    ST_MEM = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_ADV,
    ACT_LU,
    ACT_MUL,
    ACT_FREEZE
  } act_t;

  localparam int WB_W     = 2;
  localparam int M_W      = 2;
  localparam int EX_W     = 4;
  localparam int MEM_READ = 0;
  localparam int REG_W    = 5;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard sources from the pipeline and the register-control outputs back to it.
interface hazard_ctrl_if;

  logic                       idex_memread_i;
  logic [pipe_pkg::REG_W-1:0] idex_rt_i;
  logic [pipe_pkg::REG_W-1:0] ifid_rs_i;
  logic [pipe_pkg::REG_W-1:0] ifid_rt_i;
  logic                       ifid_uses_rt_i;
  logic                       branch_taken_i;
  logic                       jump_i;
  logic                       mul_valid_i;
  logic                       dmem_req_i;
  logic                       dmem_ack_i;

  logic pc_write_o;
  logic ifid_write_o;
  logic ifid_flush_o;
  logic idex_stall_o;
  logic exmem_stall_o;
  logic memwb_stall_o;
  logic idex_bubble_o;
  logic exmem_bubble_o;

  modport master (
    output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           branch_taken_i, jump_i, mul_valid_i, dmem_req_i, dmem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_stall_o,
           exmem_stall_o, memwb_stall_o, idex_bubble_o, exmem_bubble_o
  );

  modport slave (
    input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           branch_taken_i, jump_i, mul_valid_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_stall_o,
           exmem_stall_o, memwb_stall_o, idex_bubble_o, exmem_bubble_o
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in ID/EX writes a register the IF/ID
// instruction reads. Register 0 never creates a dependency.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic             memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             uses_rt,
  output logic             lu
);

  assign lu = memread && (idex_rt != '0) &&
              ((idex_rt == ifid_rs) || (uses_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: picks advance / load-use bubble / multiply
// hold / memory freeze each cycle and drives the pipeline register controls.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT     = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz,
  output logic [1:0]   state_o,
  output logic [15:0]  stall_cnt_o,
  output logic         err_o
);

  localparam logic        MUL_HOLDS = (MUL_LAT > 1);
  localparam logic [3:0]  MUL_INIT  = MUL_HOLDS ? 4'(MUL_LAT - 2) : 4'd0;
  localparam logic [15:0] TIMEOUT   = 16'(MEM_TIMEOUT);

  state_t      state, state_nxt;
  act_t        act;
  logic [3:0]  mul_cnt, mul_cnt_nxt;
  logic [15:0] mem_cnt, mem_cnt_nxt;
  logic        lu;

  hazard_detect u_detect (
    .memread (hz.idex_memread_i),
    .idex_rt (hz.idex_rt_i),
    .ifid_rs (hz.ifid_rs_i),
    .ifid_rt (hz.ifid_rt_i),
    .uses_rt (hz.ifid_uses_rt_i),
    .lu      (lu)
  );

  // Release cycles (multiply done, memory ack) fall through to the RUN-style
  // load-use check via the default action.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_nxt   = state;
    mul_cnt_nxt = mul_cnt;
    mem_cnt_nxt = mem_cnt;
    act         = lu ? ACT_LU : ACT_ADV;
    case (state)
      ST_RUN: begin
        if (hz.dmem_req_i && !hz.dmem_ack_i) begin
          act         = ACT_FREEZE;
          state_nxt   = ST_MEM;
          mem_cnt_nxt = 16'd1;
        end else if (hz.mul_valid_i && MUL_HOLDS) begin
          act         = ACT_MUL;
          state_nxt   = ST_MUL;
          mul_cnt_nxt = MUL_INIT;
        end
      end
      ST_MUL: begin
        if (mul_cnt != 4'd0) begin
          act         = ACT_MUL;
          mul_cnt_nxt = mul_cnt - 4'd1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_MEM: begin
        mem_cnt_nxt = sat_inc16(mem_cnt);
        if (!hz.dmem_ack_i) act = ACT_FREEZE;
        else                state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    hz.pc_write_o     = 1'b1;
    hz.ifid_write_o   = 1'b1;
    hz.idex_stall_o   = 1'b0;
    hz.exmem_stall_o  = 1'b0;
    hz.memwb_stall_o  = 1'b0;
    hz.idex_bubble_o  = 1'b0;
    hz.exmem_bubble_o = 1'b0;
    case (act)
      ACT_LU: begin
        hz.pc_write_o    = 1'b0;
        hz.ifid_write_o  = 1'b0;
        hz.idex_bubble_o = 1'b1;
      end
      ACT_MUL: begin
        hz.pc_write_o     = 1'b0;
        hz.ifid_write_o   = 1'b0;
        hz.idex_stall_o   = 1'b1;
        hz.exmem_bubble_o = 1'b1;
      end
      ACT_FREEZE: begin
        hz.pc_write_o    = 1'b0;
        hz.ifid_write_o  = 1'b0;
        hz.idex_stall_o  = 1'b1;
        hz.exmem_stall_o = 1'b1;
        hz.memwb_stall_o = 1'b1;
      end
      default: ;
    endcase
    // A redirect seen while the front end holds is re-evaluated next cycle.
    hz.ifid_flush_o = (hz.branch_taken_i | hz.jump_i) & hz.pc_write_o;
    if (!rst_i) begin
      hz.pc_write_o     = 1'b0;
      hz.ifid_write_o   = 1'b0;
      hz.ifid_flush_o   = 1'b1;
      hz.idex_stall_o   = 1'b0;
      hz.exmem_stall_o  = 1'b0;
      hz.memwb_stall_o  = 1'b0;
      hz.idex_bubble_o  = 1'b1;
      hz.exmem_bubble_o = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= ST_RUN;
      mul_cnt     <= 4'd0;
      mem_cnt     <= 16'd0;
      stall_cnt_o <= 16'd0;
      err_o       <= 1'b0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_cnt_nxt;
      mem_cnt <= mem_cnt_nxt;
      if (!hz.pc_write_o) stall_cnt_o <= sat_inc16(stall_cnt_o);
      if (mem_cnt_nxt == TIMEOUT) err_o <= 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (MUL_LAT=4/TIMEOUT=255 and
// MUL_LAT=1/TIMEOUT=3) driven one at a time, expectations queued per cycle.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  // {pc_write, ifid_write, ifid_flush, idex_stall, exmem_stall, memwb_stall,
  //  idex_bubble, exmem_bubble}
  localparam logic [7:0] ADV    = 8'b1100_0000;
  localparam logic [7:0] ADV_FL = 8'b1110_0000;
  localparam logic [7:0] LU_H   = 8'b0000_0010;
  localparam logic [7:0] MUL_H  = 8'b0001_0001;
  localparam logic [7:0] FRZ    = 8'b0001_1100;
  localparam logic [7:0] RST    = 8'b0010_0011;

  typedef struct packed {
    logic       memread;
    logic [4:0] idex_rt;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       uses_rt;
    logic       br;
    logic       jmp;
    logic       mul;
    logic       req;
    logic       ack;
  } stim_t;

  typedef struct {
    string      name;
    bit         sel;
    logic [7:0] ctrl;
    logic [1:0] st;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  hazard_ctrl_if if_a ();
  hazard_ctrl_if if_b ();

  logic [1:0]  state_a, state_b;
  logic [15:0] scnt_a, scnt_b;
  logic        err_a, err_b;
  logic [7:0]  ctrl_a, ctrl_b;

  hazard_ctrl #(.MUL_LAT(4), .MEM_TIMEOUT(255)) dut_a (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hz          (if_a.slave),
    .state_o     (state_a),
    .stall_cnt_o (scnt_a),
    .err_o       (err_a)
  );

  hazard_ctrl #(.MUL_LAT(1), .MEM_TIMEOUT(3)) dut_b (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hz          (if_b.slave),
    .state_o     (state_b),
    .stall_cnt_o (scnt_b),
    .err_o       (err_b)
  );

  assign ctrl_a = {if_a.pc_write_o, if_a.ifid_write_o, if_a.ifid_flush_o, if_a.idex_stall_o,
                   if_a.exmem_stall_o, if_a.memwb_stall_o, if_a.idex_bubble_o, if_a.exmem_bubble_o};
  assign ctrl_b = {if_b.pc_write_o, if_b.ifid_write_o, if_b.ifid_flush_o, if_b.idex_stall_o,
                   if_b.exmem_stall_o, if_b.memwb_stall_o, if_b.idex_bubble_o, if_b.exmem_bubble_o};

  exp_t       sb[$];
  exp_t       cur;
  logic [7:0] obs_ctrl;
  logic [1:0] obs_st;
  int         tests_run    = 0;
  int         tests_failed = 0;

  // Scoreboard: every expectation queued this cycle is settled by the negedge.
  always @(negedge clk_i) begin
    while (sb.size() > 0) begin
      cur      = sb.pop_front();
      obs_ctrl = cur.sel ? ctrl_b : ctrl_a;
      obs_st   = cur.sel ? state_b : state_a;
      tests_run++;
      if (obs_ctrl !== cur.ctrl) begin
        tests_failed++;
        $display("FAIL %s ctrl actual=%b required=%b", cur.name, obs_ctrl, cur.ctrl);
      end
      tests_run++;
      if (obs_st !== cur.st) begin
        tests_failed++;
        $display("FAIL %s state actual=%0d required=%0d", cur.name, obs_st, cur.st);
      end
    end
  end

  task automatic drive(input bit sel, input stim_t s);
    stim_t sa, sbv;
    sa  = sel ? stim_t'('0) : s;
    sbv = sel ? s : stim_t'('0);
    if_a.idex_memread_i = sa.memread;
    if_a.idex_rt_i      = sa.idex_rt;
    if_a.ifid_rs_i      = sa.ifid_rs;
    if_a.ifid_rt_i      = sa.ifid_rt;
    if_a.ifid_uses_rt_i = sa.uses_rt;
    if_a.branch_taken_i = sa.br;
    if_a.jump_i         = sa.jmp;
    if_a.mul_valid_i    = sa.mul;
    if_a.dmem_req_i     = sa.req;
    if_a.dmem_ack_i     = sa.ack;
    if_b.idex_memread_i = sbv.memread;
    if_b.idex_rt_i      = sbv.idex_rt;
    if_b.ifid_rs_i      = sbv.ifid_rs;
    if_b.ifid_rt_i      = sbv.ifid_rt;
    if_b.ifid_uses_rt_i = sbv.uses_rt;
    if_b.branch_taken_i = sbv.br;
    if_b.jump_i         = sbv.jmp;
    if_b.mul_valid_i    = sbv.mul;
    if_b.dmem_req_i     = sbv.req;
    if_b.dmem_ack_i     = sbv.ack;
  endtask

  task automatic step(input string name, input bit sel, input stim_t s,
                      input logic [7:0] ctrl, input logic [1:0] st);
    exp_t e;
    drive(sel, s);
    e.name = name;
    e.sel  = sel;
    e.ctrl = ctrl;
    e.st   = st;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    rst_i = 1'b0;
    drive(1'b0, '0);
    @(posedge clk_i);
    #1;
    e.ctrl = RST;
    e.st   = 2'd0;
    e.name = "reset_a";
    e.sel  = 1'b0;
    sb.push_back(e);
    e.name = "reset_b";
    e.sel  = 1'b1;
    sb.push_back(e);
    tests_run++;
    if (scnt_a !== 16'd0 || err_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_regs actual=%0d/%b required=0/0", scnt_a, err_a);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic test_load_use;
    stim_t s;
    logic [15:0] s0;
    s0 = scnt_a;
    s = '0; s.memread = 1; s.idex_rt = 5'd8; s.ifid_rs = 5'd8;
    step("lu_rs", 0, s, LU_H, 2'd0);
    step("lu_after", 0, '0, ADV, 2'd0);
    s = '0; s.memread = 1; s.idex_rt = 5'd9; s.ifid_rt = 5'd9; s.uses_rt = 1;
    step("lu_rt", 0, s, LU_H, 2'd0);
    s.uses_rt = 0; s.ifid_rs = 5'd3;
    step("lu_rt_unused", 0, s, ADV, 2'd0);
    s = '0; s.memread = 1;
    step("lu_r0", 0, s, ADV, 2'd0);
    s = '0; s.idex_rt = 5'd8; s.ifid_rs = 5'd8;
    step("lu_noload", 0, s, ADV, 2'd0);
    tests_run++;
    if (scnt_a !== s0 + 16'd2) begin
      tests_failed++;
      $display("FAIL lu_stall_cnt actual=%0d required=%0d", scnt_a, s0 + 16'd2);
    end
  endtask

  task automatic test_branch_flush;
    stim_t s;
    s = '0; s.memread = 1; s.idex_rt = 5'd8; s.ifid_rs = 5'd8; s.br = 1;
    step("br_in_lu", 0, s, LU_H, 2'd0);
    s = '0; s.br = 1;
    step("br_free", 0, s, ADV_FL, 2'd0);
    s = '0; s.jmp = 1;
    step("jmp_free", 0, s, ADV_FL, 2'd0);
    step("br_idle", 0, '0, ADV, 2'd0);
  endtask

  task automatic test_mul;
    stim_t s;
    logic [15:0] s0;
    s0 = scnt_a;
    s = '0; s.mul = 1;
    step("mul_enter", 0, s, MUL_H, 2'd0);
    s.req = 1;
    step("mul_hold1_req", 0, s, MUL_H, 2'd1);
    s.req = 0;
    step("mul_hold2", 0, s, MUL_H, 2'd1);
    s.br = 1;
    step("mul_release_br", 0, s, ADV_FL, 2'd1);
    step("mul_done", 0, '0, ADV, 2'd0);
    tests_run++;
    if (scnt_a !== s0 + 16'd3) begin
      tests_failed++;
      $display("FAIL mul_stall_cnt actual=%0d required=%0d", scnt_a, s0 + 16'd3);
    end
  endtask

  task automatic test_back_to_back;
    stim_t s;
    s = '0; s.mul = 1; s.memread = 1; s.idex_rt = 5'd8; s.ifid_rs = 5'd8;
    step("b2b_mul_over_lu", 0, s, MUL_H, 2'd0);
    step("b2b_hold1", 0, s, MUL_H, 2'd1);
    step("b2b_hold2", 0, s, MUL_H, 2'd1);
    step("b2b_release_lu", 0, s, LU_H, 2'd1);
    step("b2b_idle", 0, '0, ADV, 2'd0);
  endtask

  task automatic test_miss;
    stim_t s;
    logic [15:0] s0;
    s0 = scnt_a;
    s = '0; s.req = 1;
    step("miss_enter", 0, s, FRZ, 2'd0);
    for (int i = 0; i < 4; i++) step("miss_hold", 0, s, FRZ, 2'd2);
    s.ack = 1;
    step("miss_ack", 0, s, ADV, 2'd2);
    step("miss_idle", 0, '0, ADV, 2'd0);
    tests_run++;
    if (scnt_a !== s0 + 16'd5) begin
      tests_failed++;
      $display("FAIL miss_stall_cnt actual=%0d required=%0d", scnt_a, s0 + 16'd5);
    end
    tests_run++;
    if (err_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL miss_no_err actual=%b required=0", err_a);
    end
    s = '0; s.req = 1; s.ack = 1;
    step("hit", 0, s, ADV, 2'd0);
    s.ack = 0;
    step("miss2_enter", 0, s, FRZ, 2'd0);
    s.ack = 1; s.memread = 1; s.idex_rt = 5'd5; s.ifid_rs = 5'd5; s.br = 1;
    step("miss2_ack_lu", 0, s, LU_H, 2'd2);
    step("miss2_idle", 0, '0, ADV, 2'd0);
  endtask

  task automatic test_mul_lat1;
    stim_t s;
    s = '0; s.mul = 1; s.req = 1;
    step("l1_miss_first", 1, s, FRZ, 2'd0);
    s.ack = 1;
    step("l1_ack", 1, s, ADV, 2'd2);
    s = '0; s.mul = 1;
    step("l1_mul_nohold", 1, s, ADV, 2'd0);
    step("l1_idle", 1, '0, ADV, 2'd0);
    tests_run++;
    if (scnt_b !== 16'd1) begin
      tests_failed++;
      $display("FAIL l1_stall_cnt actual=%0d required=1", scnt_b);
    end
  endtask

  task automatic test_timeout;
    stim_t s;
    s = '0; s.req = 1;
    step("to_enter", 1, s, FRZ, 2'd0);
    tests_run++;
    if (err_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_err_c1 actual=%b required=0", err_b);
    end
    step("to_c1", 1, s, FRZ, 2'd2);
    tests_run++;
    if (err_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_err_c2 actual=%b required=0", err_b);
    end
    step("to_c2", 1, s, FRZ, 2'd2);
    tests_run++;
    if (err_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_err_c3 actual=%b required=1", err_b);
    end
    step("to_c3", 1, s, FRZ, 2'd2);
    step("to_c4", 1, s, FRZ, 2'd2);
    s.ack = 1;
    step("to_ack", 1, s, ADV, 2'd2);
    step("to_idle", 1, '0, ADV, 2'd0);
    tests_run++;
    if (err_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_err_sticky actual=%b required=1", err_b);
    end
    s.ack = 0;
    step("rst_mem_enter", 1, s, FRZ, 2'd0);
    step("rst_mem_hold", 1, s, FRZ, 2'd2);
    rst_i = 1'b0;
    step("rst_mem_forced", 1, s, RST, 2'd2);
    rst_i = 1'b1;
    tests_run++;
    if (state_b !== 2'd0 || err_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mem_abort actual=%0d/%b required=0/0", state_b, err_b);
    end
    step("rst_mem_after", 1, '0, ADV, 2'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch_flush();
    test_mul();
    test_back_to_back();
    test_miss();
    test_mul_lat1();
    test_timeout();
    @(negedge clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage core. Per cycle it decides which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) advance, hold or load a bubble. It resolves load-use hazards, multi-cycle multiply occupancy in EX, data-memory wait states and taken branch/jump flushes. Its outputs drive the `stall_i`/bubble controls of the pipeline registers, including the ID/EX register's `stall_i`.

## Interface
Parameters:
- `MUL_LAT`, 4: total EX-stage cycles for a multiply; valid range 1–16.
- `MEM_TIMEOUT`, 255: MEM-state cycles before `err_o` is raised; valid range 1–65535.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `idex_memread_i`  in  1  ID/EX holds a load (M[0]).
- `idex_rt_i`  in  5  ID/EX destination register of the load.
- `ifid_rs_i`, `ifid_rt_i`  in  5 each  source registers of the instruction in IF/ID.
- `ifid_uses_rt_i`  in  1  IF/ID instruction reads RT.
- `branch_taken_i`, `jump_i`  in  1 each  ID-stage redirect.
- `mul_valid_i`  in  1  ID/EX holds a multiply.
- `dmem_req_i`, `dmem_ack_i`  in  1 each  MEM-stage access this cycle / access completes this cycle.
- `pc_write_o`, `ifid_write_o`  out  1 each  PC / IF/ID advance enables.
- `ifid_flush_o`  out  1  IF/ID loads a NOP.
- `idex_stall_o`, `exmem_stall_o`, `memwb_stall_o`  out  1 each  hold the register.
- `idex_bubble_o`, `exmem_bubble_o`  out  1 each  register loads zero control fields.
- `state_o`  out  2  RUN=0, MUL=1, MEM=2.
- `stall_cnt_o`  out  16  saturating count of cycles with `pc_write_o`=0.
- `err_o`  out  1  sticky memory timeout.

## Operation
- Outputs are combinational from state and inputs. `state`, `mul_cnt` (4b), `mem_cnt` (16b), `stall_cnt_o` and `err_o` are registered.
- Default "advance": `pc_write_o`=`ifid_write_o`=1; all stalls, bubbles and flush 0.
- Load-use hazard (LU) is `idex_memread_i` & (`idex_rt_i`≠0) & (`idex_rt_i`==`ifid_rs_i` | (`ifid_uses_rt_i` & `idex_rt_i`==`ifid_rt_i`)).
- "Freeze-all" means `pc_write_o`=`ifid_write_o`=0 and `idex_stall_o`=`exmem_stall_o`=`memwb_stall_o`=1.
- RUN, priority order:
  - `dmem_req_i` & ~`dmem_ack_i`: freeze-all; go to MEM; `mem_cnt`←1.
  - else `mul_valid_i` & `MUL_LAT`>1: PC/IF/ID hold, `idex_stall_o`=1, `exmem_bubble_o`=1; go to MUL; `mul_cnt`←`MUL_LAT`−2.
  - else LU: PC/IF/ID hold, `idex_bubble_o`=1, `idex_stall_o`=0.
  - else advance.
- MUL:
  - `mul_cnt`≠0: same hold/bubble as MUL entry; `mul_cnt`−1.
  - `mul_cnt`==0: release and go to RUN. This cycle, `mul_valid_i` is ignored; LU and flush are evaluated as in RUN.
  - `dmem_req_i` is ignored throughout MUL (MEM holds a bubble).
- MEM:
  - Freeze-all until `dmem_ack_i`. In the ack cycle, evaluate LU and flush as in RUN (mul is not re-entered that cycle), then go to RUN.
  - `mem_cnt` saturating +1 per cycle; `mem_cnt`==`MEM_TIMEOUT` sets `err_o`. State stays MEM until ack.
- `ifid_flush_o` = (`branch_taken_i`|`jump_i`) & `pc_write_o`. A redirect during any hold is suppressed; ID re-evaluates it next cycle.
- `stall_cnt_o` is +1 each cycle `pc_write_o`=0, saturating at 0xFFFF.
- `err_o` is cleared only by reset.

## Timing
- Reset (`rst_i`=0 at an edge): `state`=RUN, counters 0, `err_o`=0, `stall_cnt_o`=0.
- While `rst_i`=0, outputs are forced: `pc_write_o`=0, `ifid_write_o`=0, `ifid_flush_o`=1, `idex_bubble_o`=1, `exmem_bubble_o`=1, all stalls 0.
- Reset asserted mid-MUL or mid-MEM aborts to RUN at the next edge.
- LU costs exactly 1 cycle.
- A multiply holds ID/EX for `MUL_LAT`−1 cycles; `MUL_LAT`=1 means no hold.
- A miss costs N cycles, where N is the number of cycles with `dmem_ack_i` low.
- A redirect costs 1 flush cycle when not held.

## Structure
- Shared package `pipe_pkg` holds:
  - state encoding (`ST_RUN`, `ST_MUL`, `ST_MEM`);
  - control-field widths (WB=2, M=2, EX=4), also used by the pipeline registers;
  - the `MEM_READ` bit index (0).
- One natural sub-module, `hazard_detect`: the combinational LU comparator, instantiated inside `hazard_ctrl`.

## Test plan
- LU: `idex_memread_i`=1, `idex_rt_i`=8, `ifid_rs_i`=8 → exactly one cycle of `pc_write_o`=0, `idex_bubble_o`=1. With `idex_rt_i`=0 → no stall.
- Mul, `MUL_LAT`=4, `mul_valid_i` held high → 3 cycles of `idex_stall_o`=1 and `exmem_bubble_o`=1, `state_o` 0→1→1→0; `stall_cnt_o` +3.
- Miss: `dmem_req_i`=1 with ack low 5 cycles, then high → freeze-all for 5 cycles, release on the ack cycle, `state_o`=2 throughout the hold.
- Branch taken during LU cycle → `ifid_flush_o`=0. Branch taken next cycle with no hazard → `ifid_flush_o`=1.
- Timeout, `MEM_TIMEOUT`=3: ack never returns → `err_o`=1 from cycle 3 of MEM, and stays 1 after the later ack. Reset mid-MEM → `state_o`=0, `err_o`=0.
- `MUL_LAT`=1, with a miss arriving in the same cycle as a mul → MEM is taken first, and there is no MUL hold afterwards.
